// File: rtl/pc_step_unit.sv
// pc_step_unit: program-counter sequencer for the k6502 datapath family.
// Holds the PC and performs hold, increment, absolute load and signed
// relative branch. With FAST_BRANCH=0, a branch that crosses a page first
// shows the "wrong page" address, then spends one FIXUP cycle adjusting PCH.
//
// Ports:
//   ph0        clock, rising edge active
//   reset_n    synchronous active-low reset
//   cmd        0 HOLD, 1 INC, 2 LOAD, 3 BRANCH
//   cmd_valid  cmd / ld_addr / offset valid this cycle
//   cmd_ready  unit accepts a command (combinational from state only)
//   ld_addr    absolute LOAD target
//   offset     two's-complement BRANCH displacement
//   pc         current program counter (registered)
//   page_cross one-cycle pulse when a branch resolves across a page
module pc_step_unit #(
    parameter int unsigned           ADDR_W      = 16,
    parameter int unsigned           PAGE_W      = 8,
    parameter logic [ADDR_W-1:0]     RESET_PC    = 16'hFFFC,
    parameter bit                    FAST_BRANCH = 1'b0
) (
    input  logic              ph0,
    input  logic              reset_n,
    input  logic [1:0]        cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [PAGE_W-1:0] offset,
    output logic [ADDR_W-1:0] pc,
    output logic              page_cross
);

    localparam int unsigned HI_W = ADDR_W - PAGE_W;
    localparam int unsigned S_W  = PAGE_W + 2;

    localparam logic [1:0] CMD_INC    = 2'd1;
    localparam logic [1:0] CMD_LOAD   = 2'd2;
    localparam logic [1:0] CMD_BRANCH = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        FIXUP = 1'b1
    } state_t;

    state_t            state;
    logic              fix_dec;

    logic [PAGE_W-1:0] pcl;
    logic [HI_W-1:0]   pch;
    logic [S_W-1:0]    br_sum;
    logic              br_cross;
    logic [HI_W-1:0]   pch_adj;

    assign pcl = pc[PAGE_W-1:0];
    assign pch = pc[ADDR_W-1:PAGE_W];

    // Low-half sum with two guard bits; any nonzero guard bit means the
    // signed result left the current page (carry out or borrow).
    assign br_sum   = {2'b00, pcl} + {{2{offset[PAGE_W-1]}}, offset};
    assign br_cross = |br_sum[S_W-1:PAGE_W];

    // Page adjust direction follows the offset sign.
    assign pch_adj = offset[PAGE_W-1] ? (pch - HI_W'(1)) : (pch + HI_W'(1));

    assign cmd_ready = (state == IDLE);

    // Sequencer state, PC and page_cross pulse.
    always_ff @(posedge ph0) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            state      <= IDLE;
            page_cross <= 1'b0;
            fix_dec    <= 1'b0;
        end else begin
            page_cross <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_INC:  pc <= pc + ADDR_W'(1);
                            CMD_LOAD: pc <= ld_addr;
                            CMD_BRANCH: begin
                                if (!br_cross) begin
                                    pc <= {pch, br_sum[PAGE_W-1:0]};
                                end else if (FAST_BRANCH) begin
                                    pc         <= {pch_adj, br_sum[PAGE_W-1:0]};
                                    page_cross <= 1'b1;
                                end else begin
                                    pc      <= {pch, br_sum[PAGE_W-1:0]};
                                    fix_dec <= offset[PAGE_W-1];
                                    state   <= FIXUP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                FIXUP: begin
                    pc[ADDR_W-1:PAGE_W] <= fix_dec ? (pch - HI_W'(1)) : (pch + HI_W'(1));
                    page_cross          <= 1'b1;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
